// File: rtl/conv_mxfptobf16.sv
// MX block decoder: k narrow FP elements plus one shared E8M0 scale are
// expanded into k bf16 values, `lanes` elements per cycle, one block in flight.

// Decodes one element code under the shared scale into an exact bf16 value.
module conv_mxfptobf16_lane #(
  parameter int exp_width = 3,
  parameter int man_width = 2,
  parameter int bit_width = 1 + exp_width + man_width
) (
  input  logic [bit_width-1:0] code,
  input  logic [7:0]           scale,
  output logic [15:0]          bf16
);
  localparam int bias = (1 << (exp_width - 1)) - 1;

  logic                 sgn;
  logic [exp_width-1:0] e;
  logic [man_width-1:0] m;
  logic [man_width-1:0] m_sub;
  logic [6:0]           mant;
  int                   p;
  int                   ex;

  assign sgn = code[bit_width-1];
  assign e   = code[bit_width-2 -: exp_width];
  assign m   = code[man_width-1:0];

  // Classify the element, form the rebiased exponent and pick the result
  always_comb begin
    p = 0;
    for (int i = 0; i < man_width; i++)
      if (m[i]) p = i;
    // subnormal: drop the leading one, left-align what remains below it
    m_sub = m << (man_width - p);
    if (e != '0) begin
      ex   = int'(e) - bias + int'(scale);
      mant = {m, {(7 - man_width){1'b0}}};
    end else begin
      ex   = 1 - bias - (man_width - p) + int'(scale);
      mant = {m_sub, {(7 - man_width){1'b0}}};
    end
    // NaN scale dominates everything, then zero, then range clamps
    if (scale == 8'hFF)             bf16 = 16'h7FC0;
    else if (e == '0 && m == '0)    bf16 = {sgn, 15'd0};
    else if (ex >= 255)             bf16 = {sgn, 15'h7F80};
    else if (ex <= 0)               bf16 = {sgn, 15'd0};
    else                            bf16 = {sgn, ex[7:0], mant};
  end
endmodule

module conv_mxfptobf16 #(
  parameter int exp_width = 3,
  parameter int man_width = 2,
  parameter int bit_width = 1 + exp_width + man_width,
  parameter int k         = 32,
  parameter int lanes     = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [k-1:0][bit_width-1:0]   i_mx_vec,
  input  logic [7:0]                    i_mx_exp,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [k-1:0][15:0]            o_bf16_vec
);
  localparam int groups = k / lanes;
  localparam int cnt_w  = (groups > 1) ? $clog2(groups) : 1;
  localparam int idx_w  = (k > 1) ? $clog2(k) : 1;

  typedef enum logic [1:0] {IDLE, CONV, OUT} state_t;

  state_t                          state_q, state_d;
  logic [cnt_w-1:0]                cnt_q;
  logic [k-1:0][bit_width-1:0]     vec_q;
  logic [7:0]                      exp_q;
  logic [k-1:0][15:0]              out_q;
  logic [lanes-1:0][idx_w-1:0]     idx;
  logic [lanes-1:0][15:0]          dec;
  logic                            last;

  assign last = (cnt_q == cnt_w'(groups - 1));

  // Lane g of the current group works on element cnt*lanes+g
  for (genvar g = 0; g < lanes; g++) begin : g_lane
    assign idx[g] = idx_w'(int'(cnt_q) * lanes + g);
    conv_mxfptobf16_lane #(
      .exp_width (exp_width),
      .man_width (man_width),
      .bit_width (bit_width)
    ) u_lane (
      .code  (vec_q[idx[g]]),
      .scale (exp_q),
      .bf16  (dec[g])
    );
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: capture in IDLE, k/lanes conversion cycles, hold until taken
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_valid) state_d = CONV;
      CONV:    if (last)    state_d = OUT;
      OUT:     if (i_ready) state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // Handshake outputs are pure functions of state, so they never overlap
  always_comb begin
    o_ready = (state_q == IDLE);
    o_valid = (state_q == OUT);
  end

  // Datapath: private copy of the block, group counter, result register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
      vec_q <= '0;
      exp_q <= '0;
      out_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (i_valid) begin
          vec_q <= i_mx_vec;
          exp_q <= i_mx_exp;
          cnt_q <= '0;
        end
        CONV: begin
          cnt_q <= cnt_q + 1'b1;
          for (int l = 0; l < lanes; l++) out_q[idx[l]] <= dec[l];
        end
        default: ;
      endcase
    end
  end

  assign o_bf16_vec = out_q;
endmodule

// File: tb/tb_conv_mxfptobf16.sv
// Directed + randomized bench for the MX block decoder, default E3M2, k=32.
module tb_conv_mxfptobf16;
  localparam int EW = 3;
  localparam int MW = 2;
  localparam int BW = 1 + EW + MW;
  localparam int K  = 32;
  localparam int L  = 8;
  localparam int BIAS = (1 << (EW - 1)) - 1;

  typedef logic [K-1:0][BW-1:0] vec_t;

  logic              i_clk = 0;
  logic              i_rst = 1;
  logic              i_valid = 0;
  logic              o_ready;
  vec_t              i_mx_vec = '0;
  logic [7:0]        i_mx_exp = '0;
  logic              o_valid;
  logic              i_ready = 0;
  logic [K-1:0][15:0] o_bf16_vec;

  int errs = 0;
  int nchk = 0;

  conv_mxfptobf16 #(.exp_width(EW), .man_width(MW), .k(K), .lanes(L)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_mx_vec   (i_mx_vec),
    .i_mx_exp   (i_mx_exp),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_bf16_vec (o_bf16_vec)
  );

  always #5 i_clk = ~i_clk;

  // Reference: value = sig * 2^sh as exact integers, then normalise to bf16
  function automatic logic [15:0] ref_bf16(input logic [BW-1:0] c, input logic [7:0] x);
    int s, e, m, sig, sh, lz, ex;
    s = int'(c[BW-1]);
    e = int'(c[BW-2:MW]);
    m = int'(c[MW-1:0]);
    if (x == 8'hFF) return 16'h7FC0;
    if (e == 0 && m == 0) return 16'(s << 15);
    if (e != 0) begin sig = (1 << MW) + m; sh = e - BIAS - MW; end
    else        begin sig = m;             sh = 1 - BIAS - MW; end
    sh = sh + int'(x) - 127;
    lz = 0;
    while ((sig >> (lz + 1)) != 0) lz++;
    ex = sh + lz + 127;
    if (ex >= 255) return 16'((s << 15) | 32'h7F80);
    if (ex <= 0)   return 16'(s << 15);
    return 16'((s << 15) | (ex << 7) | ((sig - (1 << lz)) << (7 - lz)));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic vec_t rnd_vec();
    vec_t v;
    for (int i = 0; i < K; i++) v[i] = BW'($urandom);
    return v;
  endfunction

  function automatic vec_t fill(input logic [BW-1:0] c);
    vec_t v;
    for (int i = 0; i < K; i++) v[i] = c;
    return v;
  endfunction

  // Present a block at a negedge; the following posedge must capture it
  task automatic start(input vec_t v, input logic [7:0] x);
    @(negedge i_clk);
    i_valid  = 1;
    i_mx_vec = v;
    i_mx_exp = x;
    chk("ready_idle", 32'(o_ready), 32'd1);
  endtask

  // Wait for o_valid, check latency, backpressure hold and every element
  task automatic collect(input string tag, input vec_t v, input logic [7:0] x, input int hold);
    int lat;
    logic [K-1:0][15:0] snap;
    lat = 0;
    do begin
      @(negedge i_clk);
      lat++;
      if (lat == 1) begin
        i_valid  = 0;
        i_mx_vec = rnd_vec();      // captured copy must be used
        i_mx_exp = 8'($urandom);
      end
    end while (!o_valid && lat < 20);
    chk({tag, "_lat"}, 32'(lat), 32'd5);
    chk({tag, "_rdy_out"}, 32'(o_ready), 32'd0);
    snap = o_bf16_vec;
    repeat (hold) @(negedge i_clk);
    if (hold > 0) begin
      chk({tag, "_hold_vld"}, 32'(o_valid), 32'd1);
      chk({tag, "_hold_rdy"}, 32'(o_ready), 32'd0);
      nchk++;
      assert (o_bf16_vec === snap) else begin
        errs++;
        $error("FAIL %s_hold_stable: output vector changed under backpressure", tag);
      end
    end
    for (int i = 0; i < K; i++)
      chk($sformatf("%s_el%0d", tag, i), 32'(o_bf16_vec[i]), 32'(ref_bf16(v[i], x)));
  endtask

  task automatic release_out(input string tag);
    i_ready = 1;
    @(negedge i_clk);
    i_ready = 0;
    chk({tag, "_vld_drop"}, 32'(o_valid), 32'd0);
    chk({tag, "_rdy_back"}, 32'(o_ready), 32'd1);
  endtask

  task automatic run(input string tag, input vec_t v, input logic [7:0] x);
    start(v, x);
    collect(tag, v, x, 0);
    release_out(tag);
  endtask

  initial begin
    vec_t v, v2;
    logic [7:0] x;

    // Reset state
    repeat (2) @(negedge i_clk);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_vec_or", 32'(|o_bf16_vec), 32'd0);
    i_rst = 0;
    @(negedge i_clk);
    chk("post_rst_valid", 32'(o_valid), 32'd0);

    // Normal values
    v = '0; v[0] = 6'b0_011_00; v[1] = 6'b1_111_11;
    start(v, 8'd127);
    collect("norm", v, 8'd127, 0);
    chk("norm_e0_lit", 32'(o_bf16_vec[0]), 32'h3F80);
    chk("norm_e1_lit", 32'(o_bf16_vec[1]), 32'hC1E0);
    chk("norm_e2_lit", 32'(o_bf16_vec[2]), 32'h0000);
    release_out("norm");

    // Subnormal elements
    v = fill(6'b0_000_01);
    start(v, 8'd127);
    collect("sub1", v, 8'd127, 0);
    chk("sub1_lit", 32'(o_bf16_vec[31]), 32'h3D80);
    release_out("sub1");
    v = fill(6'b1_000_10);
    start(v, 8'd127);
    collect("sub2", v, 8'd127, 0);
    chk("sub2_lit", 32'(o_bf16_vec[17]), 32'hBE00);
    release_out("sub2");

    // Overflow / underflow
    v = fill(6'b1_111_11);
    start(v, 8'd254);
    collect("ovf", v, 8'd254, 0);
    chk("ovf_lit", 32'(o_bf16_vec[5]), 32'hFF80);
    release_out("ovf");
    v = '0; v[0] = 6'b0_001_00; v[1] = 6'b1_001_00; v[2] = 6'b0_111_11;
    start(v, 8'd0);
    collect("unf", v, 8'd0, 0);
    chk("unf_pos_lit", 32'(o_bf16_vec[0]), 32'h0000);
    chk("unf_neg_lit", 32'(o_bf16_vec[1]), 32'h8000);
    release_out("unf");

    // NaN scale
    v = rnd_vec();
    start(v, 8'hFF);
    collect("nan", v, 8'hFF, 0);
    chk("nan_lit", 32'(o_bf16_vec[9]), 32'h7FC0);
    release_out("nan");

    // Random blocks, mid-range and full-range scales
    for (int b = 0; b < 6; b++) begin
      v = rnd_vec();
      x = (b < 3) ? 8'($urandom_range(100, 160)) : 8'($urandom_range(0, 254));
      run($sformatf("rnd%0d", b), v, x);
    end

    // Backpressure for 10 cycles, then back-to-back with i_valid held high
    v = rnd_vec();
    x = 8'($urandom_range(110, 140));
    start(v, x);
    collect("bp", v, x, 10);
    v2 = rnd_vec();
    i_ready  = 1;
    i_valid  = 1;
    i_mx_vec = v2;
    i_mx_exp = 8'd127;
    @(negedge i_clk);
    i_ready = 0;
    chk("b2b_idle_rdy", 32'(o_ready), 32'd1);
    chk("b2b_idle_vld", 32'(o_valid), 32'd0);
    collect("b2b", v2, 8'd127, 0);
    release_out("b2b");

    // Reset during the second conversion cycle
    v = rnd_vec();
    start(v, 8'd127);
    @(negedge i_clk);
    i_valid = 0;
    @(negedge i_clk);
    i_rst = 1;
    @(negedge i_clk);
    i_rst = 0;
    chk("mrst_vld", 32'(o_valid), 32'd0);
    chk("mrst_rdy", 32'(o_ready), 32'd1);
    chk("mrst_vec_or", 32'(|o_bf16_vec), 32'd0);
    repeat (8) @(negedge i_clk);
    chk("mrst_idle_vld", 32'(o_valid), 32'd0);
    v = rnd_vec();
    run("after_rst", v, 8'd130);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
